// File: rtl/dff_share_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the DFF share arbiter.
package dff_share_pkg;

    localparam int unsigned N_REQ_DEF      = 4;
    localparam int unsigned WIDTH_DEF      = 8;
    localparam int unsigned SETTLE_CYC_DEF = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Ceiling log2, returns at least 1 so derived vectors never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bundle of the DFF share arbiter.
interface dff_share_arbiter_if
    import dff_share_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    localparam int unsigned IDX_W = clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       grant;
    logic [IDX_W-1:0]       owner;
    logic [WIDTH-1:0]       q;
    logic                   done;
    logic                   busy;

    // Requester side: drives requests and data, observes the arbiter.
    modport master (
        output req, data_in,
        input  grant, owner, q, done, busy
    );

    // Arbiter side.
    modport slave (
        input  req, data_in,
        output grant, owner, q, done, busy
    );

endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping.
module rr_pick
    import dff_share_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   lsb;
    logic [IDX_W:0]     sum;

    // Rotate so rr_ptr lands at bit 0, take lowest set bit, then undo the rotation.
    always_comb begin
        dbl = {req, req} >> rr_ptr;
        rot = dbl[N_REQ-1:0];
        lsb = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                lsb = IDX_W'(i);
            end
        end
        sum = {1'b0, lsb} + {1'b0, rr_ptr};
        if (sum >= NREQ_W) begin
            idx = IDX_W'(sum - NREQ_W);
        end else begin
            idx = sum[IDX_W-1:0];
        end
        valid = |req;
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin sharing of one capture register: grant, load, settle, done.
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input logic                clk,
    input logic                rst_n,
    dff_share_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = clog2(N_REQ);
    localparam int unsigned CNT_W = clog2(SETTLE_CYC);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Next-state: requests are only looked at in IDLE; a granted transaction always runs out.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        q_d      = q_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d           = ST_LOAD;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    busy_d            = 1'b1;
                end
            end
            ST_LOAD: begin
                q_d     = bus.data_in[owner_q*WIDTH +: WIDTH];
                cnt_d   = CNT_W'(SETTLE_CYC - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                // Pointer moves only on completion so an aborted transfer keeps its priority.
                rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            q_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            q_q      <= q_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.owner = owner_q;
    assign bus.q     = q_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_dff_share_arbiter;

    logic clk;
    logic rst_n;

    int errors;
    int checks;

    dff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus1 ();
    dff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus2 ();

    dff_share_arbiter #(
        .N_REQ      (4),
        .WIDTH      (8),
        .SETTLE_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    dff_share_arbiter #(
        .N_REQ      (4),
        .WIDTH      (8),
        .SETTLE_CYC (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic [7:0]  q;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic [7:0] qv, input logic d, input logic b);
        chk({tag, ".grant"}, 32'(bus1.grant), 32'(g));
        chk({tag, ".owner"}, 32'(bus1.owner), 32'(o));
        chk({tag, ".q"},     32'(bus1.q),     32'(qv));
        chk({tag, ".done"},  32'(bus1.done),  32'(d));
        chk({tag, ".busy"},  32'(bus1.busy),  32'(b));
    endtask

    initial begin
        int k;
        int ph;
        logic [3:0] exp_g;
        logic [7:0] exp_q;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus1.req     = '0;
        bus1.data_in = '0;
        bus2.req     = '0;
        bus2.data_in = '0;

        // Reset held with all requests up, then a single request for slice 2.
        vecs[0] = '{1'b0, 4'hF, 32'h0000_0000, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'hF, 32'h0000_0000, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'h4, 32'h00A5_0000, 4'h4, 2'd2, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 4'h0, 32'h00A5_0000, 4'h4, 2'd2, 8'hA5, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 4'h0, 32'h00A5_0000, 4'h4, 2'd2, 8'hA5, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 4'h0, 32'h00A5_0000, 4'h4, 2'd2, 8'hA5, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 4'h0, 32'h00A5_0000, 4'h0, 2'd2, 8'hA5, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst_n        = vecs[i].rst_n;
            bus1.req     = vecs[i].req;
            bus1.data_in = vecs[i].data;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].q,
                    vecs[i].done, vecs[i].busy);
        end

        // All requesters from reset: owners rotate 0..3 every 5 cycles.
        rst_n        = 1'b0;
        bus1.req     = 4'hF;
        bus1.data_in = 32'h4433_2211;
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            k  = (c - 1) / 5;
            ph = (c - 1) % 5;
            exp_g = (ph < 4) ? (4'b0001 << (k % 4)) : 4'b0000;
            chk($sformatf("rr c%0d grant", c), 32'(bus1.grant), 32'(exp_g));
            chk($sformatf("rr c%0d done", c), 32'(bus1.done), 32'(ph == 3));
            if (ph < 4) begin
                chk($sformatf("rr c%0d owner", c), 32'(bus1.owner), 32'(k % 4));
            end
            if (ph >= 1) begin
                exp_q = 8'h11 * 8'((k % 4) + 1);
                chk($sformatf("rr c%0d q", c), 32'(bus1.q), 32'(exp_q));
            end
        end

        // Let the fifth transaction finish with requests dropped.
        bus1.req = 4'h0;
        for (int c = 0; c < 5; c++) step();
        chk("rr drain busy", 32'(bus1.busy), 32'd0);

        // Request and data withdrawn during SETTLE must not disturb the transfer.
        bus1.data_in = 32'h0000_5A00;
        bus1.req     = 4'b0010;
        step();
        chk_all("hold c1", 4'b0010, 2'd1, 8'h11, 1'b0, 1'b1);
        step();
        chk_all("hold c2", 4'b0010, 2'd1, 8'h5A, 1'b0, 1'b1);
        bus1.req     = 4'b0000;
        bus1.data_in = 32'h0000_FF00;
        step();
        chk_all("hold c3", 4'b0010, 2'd1, 8'h5A, 1'b0, 1'b1);
        step();
        chk_all("hold c4", 4'b0010, 2'd1, 8'h5A, 1'b1, 1'b1);
        step();
        chk_all("hold c5", 4'b0000, 2'd1, 8'h5A, 1'b0, 1'b0);

        // Reset during SETTLE aborts without a done pulse.
        bus1.data_in = 32'h7700_0000;
        bus1.req     = 4'b1000;
        step();
        chk_all("abort c1", 4'b1000, 2'd3, 8'h5A, 1'b0, 1'b1);
        bus1.req = 4'b0000;
        step();
        chk_all("abort c2", 4'b1000, 2'd3, 8'h77, 1'b0, 1'b1);
        step();
        chk_all("abort c3", 4'b1000, 2'd3, 8'h77, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        chk_all("abort c4", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
        rst_n    = 1'b1;
        bus1.req = 4'hF;
        step();
        chk_all("abort c5", 4'b0001, 2'd0, 8'h00, 1'b0, 1'b1);
        bus1.req = 4'h0;

        // Single settle cycle: done at c3, grants every 4 cycles.
        bus2.data_in = 32'h0000_003C;
        bus2.req     = 4'b0001;
        for (int c = 1; c <= 9; c++) begin
            step();
            ph = (c - 1) % 4;
            chk($sformatf("s1 c%0d grant", c), 32'(bus2.grant), (ph < 3) ? 32'd1 : 32'd0);
            chk($sformatf("s1 c%0d done", c), 32'(bus2.done), 32'(ph == 2));
            chk($sformatf("s1 c%0d busy", c), 32'(bus2.busy), 32'(ph < 3));
            if (c >= 2) begin
                chk($sformatf("s1 c%0d q", c), 32'(bus2.q), 32'h3C);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
Shares a single WIDTH-bit capture register among N_REQ requesters using round-robin arbitration. Each transaction is a fixed sequence: grant, load, then a programmable settle window that models the register's clock-to-output delay in whole cycles. The requester is then released with a done pulse. The block sits between requester logic and the team's timed DFF models, and sequences all writes into them.

Parameters:
N_REQ, 4, number of requesters (at least 2)
WIDTH, 8, data width of the shared register
SETTLE_CYC, 2, settle cycles after load (at least 1)
IDX_W, $clog2(N_REQ), width of the owner index (derived; do not override)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  synchronous, active-low reset, sampled on posedge clk
req  input  N_REQ  per-requester request level
data_in  input  N_REQ*WIDTH  packed write data; slice i is data_in[i*WIDTH +: WIDTH]
grant  output  N_REQ  one-hot grant to the current owner
owner  output  IDX_W  index of the current owner
q  output  WIDTH  shared register contents
done  output  1  one-cycle pulse marking end of transaction
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, q=0, grant=0, owner=0, done=0, busy=0, rr_ptr=0, cnt=0. Reset asserted mid-transaction aborts it; no done pulse is issued.
- States: IDLE, LOAD, SETTLE, DONE. All outputs are registered.
- IDLE:
  - If req!=0, pick the first set bit scanning from rr_ptr upward, wrapping modulo N_REQ.
  - Next state LOAD; grant=onehot(winner); owner=winner; busy=1.
  - If req==0, remain in IDLE.
- LOAD (1 cycle): q <= data_in slice[owner]; cnt <= SETTLE_CYC-1; next state SETTLE.
- SETTLE: if cnt==0, go to DONE; otherwise decrement cnt. SETTLE lasts exactly SETTLE_CYC cycles.
- DONE (1 cycle): done=1; grant is held; rr_ptr <= (owner+1) mod N_REQ; next state IDLE.
- On the exit from DONE: grant=0, done=0, busy=0. owner and q hold their values.
- Latency, with req sampled in IDLE at cycle 0:
  - grant visible in cycle 1
  - new q visible from cycle 2
  - done high in cycle 2+SETTLE_CYC
  - back in IDLE in cycle 3+SETTLE_CYC
  - With all requesters asserting, grants repeat every 3+SETTLE_CYC cycles.
- Once granted, a transaction always completes. Deassertion of req[owner] and changes to data_in after LOAD are ignored. q captures only in LOAD.
- New or changed req bits are sampled only in IDLE; there is no preemption.
- The round-robin pointer advances only on DONE, so an aborted (reset) transaction does not advance it.
- Invariants: grant is one-hot or zero; grant!=0 exactly when state is LOAD, SETTLE or DONE; done implies busy.

Decomposition:
- Package dff_share_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SETTLE=2'd2, ST_DONE=2'd3
  - a clog2 helper function
  - the default parameter constants
- Sub-module rr_pick: a combinational round-robin selector with inputs (req, rr_ptr) and outputs (valid, idx). It rotates req right by rr_ptr, finds the lowest set bit, and adds rr_ptr back mod N_REQ.
- The FSM, settle counter and register live in the top module.

Test Plan (N_REQ=4, WIDTH=8, SETTLE_CYC=2):
1. Hold rst_n=0 for 2 cycles with req=4'hF -> q=0, grant=0, done=0, busy=0, owner=0 throughout.
2. Drive req=4'b0100 with slice 2=8'hA5 at cycle 0 -> grant=4'b0100 in c1, q=8'hA5 from c2, done=1 only in c4, grant=0 and busy=0 in c5.
3. Drive req=4'hF with slices 8'h11,8'h22,8'h33,8'h44 from reset -> owners 0,1,2,3,0 granted at c1,c6,c11,c16,c21; q sequence 8'h11,8'h22,8'h33,8'h44.
4. Grant req[1], then drop req[1] and change slice 1 from 8'h5A to 8'hFF during SETTLE -> q stays 8'h5A; done still pulses at c4.
5. Grant req[3], then pull rst_n=0 in c3 (SETTLE) -> in c4 state IDLE, q=0, grant=0, no done pulse; the next req=4'hF grants owner 0 (rr_ptr not advanced).
6. Rebuild with SETTLE_CYC=1, drive req=4'b0001 -> done in c3; back-to-back grant period is 4 cycles.
